// File: rtl/demodulator_qpsk_if.sv
// Symbol-in / bit-out handshake bundle for the QPSK demapper.
// The slave modport is the demapper side; the master modport is its environment.
interface demodulator_qpsk_if #(
    parameter int unsigned CNT_W = 16
);
    logic             i_valid;
    logic [15:0]      I_comp;
    logic [15:0]      Q_comp;
    logic             i_ready;
    logic             o_valid;
    logic             o_data;
    logic             o_weak;
    logic             o_ready;
    logic [CNT_W-1:0] o_sym_count;

    modport master (
        output i_valid, I_comp, Q_comp, o_ready,
        input  i_ready, o_valid, o_data, o_weak, o_sym_count
    );

    modport slave (
        input  i_valid, I_comp, Q_comp, o_ready,
        output i_ready, o_valid, o_data, o_weak, o_sym_count
    );
endinterface

// File: rtl/demodulator_qpsk.sv
// Hard-decision Gray QPSK demapper: one Q15 I/Q symbol in, two bits out serially
// (b0 from I, b1 from Q), each tagged weak when its component magnitude is small.
module demodulator_qpsk #(
    parameter logic [15:0] WEAK_THR = 16'd4096,
    parameter int unsigned CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    demodulator_qpsk_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EMIT_B0 = 2'd1,
        EMIT_B1 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             b0_q, b0_d;
    logic             b1_q, b1_d;
    logic             w0_q, w0_d;
    logic             w1_q, w1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             i_ready;
    logic             accept;

    // 0x8000 has no positive counterpart in 16 bits; it saturates to 0x7FFF.
    function automatic logic [15:0] mag(input logic [15:0] x);
        if (!x[15])
            return x;
        else if (x == 16'h8000)
            return 16'h7FFF;
        else
            return ~x + 16'd1;
    endfunction

    always_comb begin
        i_ready = (state_q == IDLE) || ((state_q == EMIT_B1) && bus.o_ready);
        accept  = bus.i_valid && i_ready;
    end

    always_comb begin
        state_d = state_q;
        b0_d    = b0_q;
        b1_d    = b1_q;
        w0_d    = w0_q;
        w1_d    = w1_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.i_valid) state_d = EMIT_B0;
            end
            EMIT_B0: begin
                if (bus.o_ready) state_d = EMIT_B1;
            end
            EMIT_B1: begin
                if (bus.o_ready) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = bus.i_valid ? EMIT_B0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Decision and confidence are resolved at capture; raw I/Q is not kept.
        if (accept) begin
            b0_d = bus.I_comp[15];
            b1_d = bus.Q_comp[15];
            w0_d = mag(bus.I_comp) < WEAK_THR;
            w1_d = mag(bus.Q_comp) < WEAK_THR;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            b0_q    <= 1'b0;
            b1_q    <= 1'b0;
            w0_q    <= 1'b0;
            w1_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            w0_q    <= w0_d;
            w1_q    <= w1_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.i_ready     = i_ready;
    assign bus.o_valid     = (state_q != IDLE);
    assign bus.o_data      = (state_q == EMIT_B1) ? b1_q : b0_q;
    assign bus.o_weak      = (state_q == EMIT_B1) ? w1_q : w0_q;
    assign bus.o_sym_count = cnt_q;

endmodule

// File: doc/demodulator_qpsk.md
Name: demodulator_qpsk

Overview:
- Hard-decision Gray-mapped QPSK demapper for the receive/loopback path. It is the inverse of the transmit-side QPSK modulator.
- Accepts one Q15 I/Q symbol per handshake and emits its two bits serially, b0 first then b1, on a valid/ready bit stream toward the de-interleaver.
- Flags low-confidence bits whose component magnitude is below a threshold.
- Keeps a running count of demodulated symbols.

Parameters:
- WEAK_THR, 16'd4096, magnitude threshold (Q15, 0.125). A component with |x| < WEAK_THR marks its bit weak.
- CNT_W, 16, width of the symbol counter.

Ports:
- clk          in   1      system clock, 100 MHz
- rst_n        in   1      active-low reset, synchronous to clk
- i_valid      in   1      input symbol valid
- I_comp       in   16     in-phase component, Q15 two's complement
- Q_comp       in   16     quadrature component, Q15 two's complement
- i_ready      out  1      block can accept a symbol this cycle
- o_valid      out  1      output bit valid
- o_data       out  1      demodulated bit
- o_weak       out  1      o_data came from a component with |x| < WEAK_THR
- o_ready      in   1      downstream accepts the bit
- o_sym_count  out  CNT_W  symbols fully delivered, both bits handshaked

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low, sampled on the rising edge of clk only.
- Reset values: state=IDLE, o_valid=0, o_data=0, o_weak=0, o_sym_count=0, internal symbol registers=0. The i_ready value is then derived combinationally from state and is 1 in IDLE.
- Decision rule:
  - b0 = I_comp[15], b1 = Q_comp[15]. Negative gives 1; zero and positive give 0.
  - 0x5A82 gives 0; 0xA57E gives 1; 0x0000 gives 0; 0x8000 gives 1.
- Magnitude rule:
  - |x| = x when x[15]=0, else -x.
  - 0x8000 saturates to 0x7FFF, so it is never weak.
  - weak = (|x| < WEAK_THR), unsigned 16-bit compare.
  - Magnitude and decision are computed at symbol capture and stored as 2 bits plus 2 weak flags. The raw I/Q words are not stored.
- FSM states:
  - IDLE: o_valid=0, i_ready=1. On i_valid, capture b0, b1, w0, w1 and go to EMIT_B0.
  - EMIT_B0: o_valid=1, o_data=b0, o_weak=w0, i_ready=0. On o_ready, go to EMIT_B1. Otherwise hold all outputs stable.
  - EMIT_B1: o_valid=1, o_data=b1, o_weak=w1. i_ready = o_ready (combinational pass-through).
    - On o_ready with i_valid: increment o_sym_count, capture the new symbol, go to EMIT_B0. Back-to-back, no bubble.
    - On o_ready without i_valid: increment o_sym_count, go to IDLE.
    - No o_ready: hold all outputs; i_ready=0.
- Latency: symbol accepted at edge N gives b0 on the outputs after edge N, and b1 after the first o_ready-qualified edge following. Sustained throughput is 1 bit per cycle (1 symbol per 2 cycles) with o_ready held high.
- Handshake rules:
  - Transfers occur only on edges where valid and ready are both 1.
  - While o_valid=1 and o_ready=0, o_data and o_weak stay constant.
  - I_comp/Q_comp are ignored when i_ready=0.
- Counter: o_sym_count increments by 1 on each completed b1 handshake. It wraps from 2^CNT_W-1 to 0 with no flag.
- Reset mid-symbol: a partially emitted symbol is discarded and the count is not incremented for it. All outputs return to reset values on the next edge.
- The design has no combinational path from i_valid to o_valid. o_data, o_weak, o_valid and o_sym_count are registered or decoded from registered state only.

Test Plan:
- Reset then four symbols (5A82,5A82), (5A82,A57E), (A57E,5A82), (A57E,A57E) with o_ready=1 and i_valid=1 continuously -> bit stream 0,0,0,1,1,0,1,1 on 8 consecutive cycles. o_weak=0 throughout; o_sym_count=4; i_ready pattern 1,0,1,0,...
- Edge values (0000,8000) then (0FFF,1000) -> bits 0,1 with weak 1,0, then bits 0,0 with weak 1,0.
- Backpressure: o_ready=0 for 5 cycles while b0=1 is presented -> o_valid, o_data and o_weak are stable and i_ready=0 for all 5 cycles. The stream resumes correctly when o_ready returns to 1 and no bit is lost or duplicated.
- Bubbles: i_valid toggling randomly against a modulator-generated reference stream of 1000 random bits -> demodulated stream equals the source bits exactly and o_sym_count=500.
- Reset asserted while in EMIT_B1 with o_ready=0 -> next edge gives o_valid=0, o_sym_count=0, i_ready=1, and the pending bit is never emitted.
- Wrap: run with CNT_W=4 for 17 symbols -> o_sym_count=1 after the 17th b1 handshake.
